// File: rtl/dll_lock_ctrl.sv
// FMDLL lock controller: SAR acquisition of the DCDL delay code, then +/-1 tracking with lock detect.
// Optional macro DLL_TRACK_FILTER_EN: a tracking step needs FILT_LEN consecutive agreeing samples.
module dll_lock_ctrl #(
    parameter int CODE_W   = 6,
    parameter int SETTLE   = 4,
    parameter int LOCK_CNT = 8,
    parameter int FILT_LEN = 4
) (
    input  logic              CLK_exit,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pd_valid,
    input  logic              pd_lead,
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              locked,
    output logic              lock_lost
);

    typedef enum logic [1:0] {IDLE = 2'd0, SAR = 2'd1, TRACK = 2'd2} state_t;

`ifdef DLL_TRACK_FILTER_EN
    localparam int STEP_LEN = FILT_LEN;
`else
    localparam int STEP_LEN = 1;
`endif

    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W = $clog2(FILT_LEN + 1);

    localparam logic [CODE_W-1:0] MIDSCALE  = CODE_W'(1) << (CODE_W - 1);
    localparam logic [CODE_W-1:0] CODE_MAX  = '1;
    localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(CODE_W - 1);
    localparam logic [SET_W-1:0]  SETTLE_LD = SET_W'(SETTLE);
    localparam logic [LCK_W-1:0]  LOCK_FULL = LCK_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(STEP_LEN);

    state_t            state_reg, state_next;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [CODE_W-1:0] ref_reg, ref_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [SET_W-1:0]  settle_reg, settle_next;
    logic [LCK_W-1:0]  lcnt_reg, lcnt_next;
    logic [RUN_W-1:0]  run_reg, run_next;
    logic              dir_reg, dir_next;
    logic              locked_reg, locked_next;
    logic              lost_reg, lost_next;
    logic              busy_reg;

    logic              consume;
    logic              in_win;
    logic [RUN_W-1:0]  run_inc;
    logic [IDX_W-1:0]  idx_dec;

    assign consume = pd_valid && (settle_reg == '0);
    assign idx_dec = idx_reg - 1'b1;

    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        ref_next    = ref_reg;
        idx_next    = idx_reg;
        settle_next = (settle_reg != '0) ? settle_reg - 1'b1 : settle_reg;
        lcnt_next   = lcnt_reg;
        run_next    = run_reg;
        dir_next    = dir_reg;
        locked_next = locked_reg;
        lost_next   = 1'b0;
        in_win      = 1'b0;
        run_inc     = RUN_W'(1);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = SAR;
                    code_next   = MIDSCALE;
                    idx_next    = IDX_TOP;
                    settle_next = SETTLE_LD;
                end
            end

            SAR: begin
                if (consume) begin
                    if (!pd_lead) begin
                        code_next[idx_reg] = 1'b0;
                    end
                    if (idx_reg != '0) begin
                        code_next[idx_dec] = 1'b1;
                        idx_next           = idx_dec;
                        settle_next        = SETTLE_LD;
                    end else begin
                        state_next  = TRACK;
                        ref_next    = code_next;
                        lcnt_next   = '0;
                        run_next    = '0;
                        settle_next = SETTLE_LD;
                    end
                end
            end

            TRACK: begin
                if (start) begin
                    // Re-acquire; the pending sample is dropped and lock clears silently.
                    state_next  = SAR;
                    code_next   = MIDSCALE;
                    idx_next    = IDX_TOP;
                    settle_next = SETTLE_LD;
                    locked_next = 1'b0;
                    lcnt_next   = '0;
                end else if (consume) begin
                    run_inc  = (run_reg != '0 && pd_lead == dir_reg) ? run_reg + 1'b1 : RUN_W'(1);
                    dir_next = pd_lead;
                    if (run_inc == RUN_FULL) begin
                        run_next = '0;
                        // A step pinned at either end leaves code and settle untouched.
                        if (pd_lead && code_reg != CODE_MAX) begin
                            code_next   = code_reg + 1'b1;
                            settle_next = SETTLE_LD;
                        end else if (!pd_lead && code_reg != '0) begin
                            code_next   = code_reg - 1'b1;
                            settle_next = SETTLE_LD;
                        end
                    end else begin
                        run_next = run_inc;
                    end

                    // One extra bit so the +/-1 window does not wrap at the code limits.
                    in_win = (({1'b0, code_next} + 1'b1) >= {1'b0, ref_reg}) &&
                             ({1'b0, code_next} <= ({1'b0, ref_reg} + 1'b1));
                    if (in_win) begin
                        if (lcnt_reg != LOCK_FULL) begin
                            lcnt_next = lcnt_reg + 1'b1;
                        end
                        locked_next = (lcnt_next == LOCK_FULL);
                    end else begin
                        ref_next    = code_next;
                        lcnt_next   = '0;
                        locked_next = 1'b0;
                        lost_next   = locked_reg;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_exit) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            code_reg   <= '0;
            ref_reg    <= '0;
            idx_reg    <= '0;
            settle_reg <= '0;
            lcnt_reg   <= '0;
            run_reg    <= '0;
            dir_reg    <= 1'b0;
            locked_reg <= 1'b0;
            lost_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            code_reg   <= code_next;
            ref_reg    <= ref_next;
            idx_reg    <= idx_next;
            settle_reg <= settle_next;
            lcnt_reg   <= lcnt_next;
            run_reg    <= run_next;
            dir_reg    <= dir_next;
            locked_reg <= locked_next;
            lost_reg   <= lost_next;
            busy_reg   <= (state_next == SAR);
        end
    end

    assign code      = code_reg;
    assign busy      = busy_reg;
    assign locked    = locked_reg;
    assign lock_lost = lost_reg;

endmodule

// File: doc/dll_lock_ctrl.md
# dll_lock_ctrl

Digital lock controller for the FMDLL delay line. It runs a successive-approximation search on the 6-bit DCDL delay code from phase-detector decisions, then switches to ±1 tracking and reports lock. It sits between the phase detector, which samples CLK_out against the reference, and the DCDL code input (Q[5:0]). It replaces the open-loop code path from PTC when closed-loop operation is selected.

## Interface
- CODE_W, 6, delay code width (DCDL code width).
- SETTLE, 4, cycles after any code change during which pd_valid is ignored; must be ≥1.
- LOCK_CNT, 8, consecutive in-window tracking decisions required to assert locked.
- FILT_LEN, 4, agreeing samples required per tracking step (filter build only).

Ports:
- CLK_exit  in  1  controller clock (reference clock).
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to (re)acquire.
- pd_valid  in  1  phase-detector sample strobe.
- pd_lead  in  1  qualified by pd_valid: 1 = output leads and needs more delay; 0 = output lags.
- code  out  CODE_W  registered delay code to DCDL.
- busy  out  1  high in SAR state.
- locked  out  1  lock indication.
- lock_lost  out  1  one-cycle pulse when locked falls in TRACK.

## Operation
States are IDLE, SAR and TRACK.

Sample consumption:
- A settle counter is loaded with SETTLE on every code change and on every state entry.
- A pd_valid that arrives while the counter is non-zero is discarded.
- The first pd_valid once the counter is zero is consumed.

IDLE:
- code holds its value.
- On start: code ← 1<<(CODE_W-1), bit index ← CODE_W-1, go to SAR.

SAR, on each consumed sample:
- If pd_lead=0, clear the bit at the current index.
- If the index is >0, set bit index-1, decrement the index and reload settle.
- If the index is 0, go to TRACK, capture code_ref ← final code and clear the lock counter.
- start is ignored in SAR.

TRACK, on each consumed sample:
- pd_lead=1 gives code+1; pd_lead=0 gives code-1.
- The code saturates at 0 and at 2^CODE_W-1. A saturated step leaves the code unchanged and does not reload settle.

Lock window:
- Each consumed sample in TRACK is one decision.
- If the post-decision code is within code_ref±1, the lock counter increments, saturating at LOCK_CNT. locked=1 while the counter equals LOCK_CNT.
- Otherwise: code_ref ← new code and the counter clears. If locked was 1, it drops and lock_lost pulses for one cycle.

Other rules:
- start in TRACK restarts SAR from midscale. locked clears without a lock_lost pulse.
- A simultaneous start and consumed sample in TRACK: start wins and the sample is discarded.

## Timing
- Reset, sampled on the CLK_exit edge with rst_n=0: state=IDLE, code=0, busy=0, locked=0, lock_lost=0, and all counters and code_ref = 0. Reset mid-SAR or mid-TRACK aborts immediately.
- code, busy, locked and lock_lost are all registered. Each updates on the edge that consumes the triggering sample or start.
- busy rises on the edge after start and falls on the edge that makes the final SAR decision.
- Minimum SAR duration is CODE_W×(SETTLE+1) cycles.
- locked asserts on the edge of the LOCK_CNT-th in-window decision.

## Configuration
- DLL_TRACK_FILTER_EN defined:
  - TRACK steps only after FILT_LEN consecutive consumed samples with the same pd_lead.
  - A disagreeing sample restarts the run at 1 with the new direction.
  - Non-stepping samples still count as lock decisions and do not reload settle.
  - SAR is unaffected.
- Undefined: every consumed TRACK sample steps.

## Test plan
- Reset: rst_n=0 for one edge during SAR → code=0, busy=0, locked=0, lock_lost=0 next cycle.
- SAR with the phase-detector model "lead iff code<37":
  - Start → code sequence 32, 48, 40, 36, 38, 37, final 36.
  - busy is high for the whole SAR and TRACK is entered.
  - Tracking alternates 36/37 and locked=1 after 8 decisions.
- Saturation with "always lead": SAR ends at 63, TRACK holds 63 with no settle reload, and locked asserts after 8 decisions.
- Lock loss: after lock at 36, move the model target to 50 → code steps 37, 38.
  - At 38, locked falls and lock_lost is high for exactly one cycle.
  - The bench relocks around 49/50.
- Settle: pd_valid pulses within 4 cycles of a code change → ignored, code unchanged; a pulse at cycle 5 is consumed.
- With DLL_TRACK_FILTER_EN: alternating lead/lag samples → code constant. Four consecutive leads → code+1 exactly once.
